dds_tune_ctrl: RTL

Front-panel tuning controller for the DDS example. It takes single-cycle pulses from the per-button debouncers, plus held-button levels, and turns them into frequency tuning word (FTW) updates. It adds hold-to-auto-repeat, a decade step-size selector and saturation at the FTW limits. The phase accumulator receives each new FTW through a valid/ready load handshake.

---
 rtl/dds_pkg.sv | 19 +
 rtl/btn_repeat_gen.sv | 55 +++++
 rtl/dds_tune_ctrl.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/dds_pkg.sv
// dds_pkg
// Shared definitions for the DDS front-panel tuning logic: default tuning
// word geometry, step-size defaults and the load FSM state encoding.
// No ports; imported by the tuning controller and its helpers.
package dds_pkg;

   localparam int DFLT_FTW_BITS    = 32;
   localparam int DFLT_FTW_MIN     = 1;
   localparam int DFLT_FTW_MAX     = 2147483647;
   localparam int DFLT_STEP_BASE   = 358;
   localparam int DFLT_STEP_LEVELS = 5;

   // IDLE: waiting for a tuning event; LOAD: a word is offered to the accumulator
   typedef enum logic {
      IDLE = 1'b0,
      LOAD = 1'b1
   } tune_state_e;

endpackage

// File: rtl/btn_repeat_gen.sv
// btn_repeat_gen
// Hold-to-auto-repeat generator for one button. While the level is held it
// fires a first pulse after HOLD_CYC held cycles and then one pulse every
// REP_CYC cycles. The initial press itself never produces a pulse here.
// Ports:
//   clk    system clock
//   rst_n  synchronous active-low reset
//   lvl    synchronised button level
//   rep_p  single-cycle auto-repeat pulse
module btn_repeat_gen
   import dds_pkg::*;
#(
   parameter int HOLD_CYC = 10,
   parameter int REP_CYC  = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic lvl,
   output logic rep_p
);

   localparam int MAX_CYC = (HOLD_CYC > REP_CYC) ? HOLD_CYC : REP_CYC;
   localparam int CNT_W   = $clog2(MAX_CYC + 1);
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);
   localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REP_CYC - 1);

   logic [CNT_W-1:0] cnt;
   logic             armed;
   logic             hit;

   // cnt holds the number of held cycles already completed in the current
   // phase, so the cycle that completes the phase sees cnt == length-1.
   // Once the hold delay has elapsed, 'armed' switches the phase length
   // to the repeat period.
   assign hit   = armed ? (cnt == REP_LAST) : (cnt == HOLD_LAST);
   assign rep_p = lvl & hit;

   // Phase counter: cleared the same cycle the level drops, restarted
   // at every pulse so the counter never has to span the whole hold time.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt   <= '0;
         armed <= 1'b0;
      end else if (!lvl) begin
         cnt   <= '0;
         armed <= 1'b0;
      end else if (hit) begin
         cnt   <= '0;
         armed <= 1'b1;
      end else begin
         cnt   <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/dds_tune_ctrl.sv
// dds_tune_ctrl
// Front-panel tuning controller. Merges debounced button pulses with
// auto-repeat, applies a decade step size with saturation at the FTW limits
// and offers each new tuning word to the phase accumulator via valid/ready.
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   up_p, dn_p, step_p   debounced single-cycle button pulses
//   up_lvl, dn_lvl       synchronised held-button levels
//   ftw_o, ftw_valid     offered tuning word and its valid flag
//   ftw_ready            accumulator accepts ftw_o this cycle
//   step_idx             current decade step level
//   at_limit             pulse when a request was clamped at a limit
module dds_tune_ctrl
   import dds_pkg::*;
#(
   parameter int  SYSCLK_FREQ   = 12000000,
   parameter int  FTW_BITS      = DFLT_FTW_BITS,
   parameter int  FTW_RESET     = 357913941,
   parameter int  FTW_MIN       = DFLT_FTW_MIN,
   parameter int  FTW_MAX       = DFLT_FTW_MAX,
   parameter int  STEP_BASE     = DFLT_STEP_BASE,
   parameter int  STEP_LEVELS   = DFLT_STEP_LEVELS,
   parameter real HOLD_DELAY    = 0.500,
   parameter real REPEAT_PERIOD = 0.100
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                up_p,
   input  logic                dn_p,
   input  logic                step_p,
   input  logic                up_lvl,
   input  logic                dn_lvl,
   output logic [FTW_BITS-1:0] ftw_o,
   output logic                ftw_valid,
   input  logic                ftw_ready,
   output logic [2:0]          step_idx,
   output logic                at_limit
);

   localparam int HOLD_CYC = $rtoi($floor(SYSCLK_FREQ * HOLD_DELAY));
   localparam int REP_CYC  = $rtoi($floor(SYSCLK_FREQ * REPEAT_PERIOD));

   localparam logic [FTW_BITS:0] MAX_W    = (FTW_BITS + 1)'(FTW_MAX);
   localparam logic [FTW_BITS:0] MIN_W    = (FTW_BITS + 1)'(FTW_MIN);
   localparam logic [2:0]        LAST_IDX = 3'(STEP_LEVELS - 1);

   tune_state_e         state_q, state_d;
   logic [FTW_BITS-1:0] step_q;
   logic [FTW_BITS-1:0] ftw_d, nxt;
   logic                valid_d, at_limit_d, clamp;
   logic                pend_up, pend_dn, pend_up_d, pend_dn_d;
   logic                go_up, go_dn;
   logic                up_rep, dn_rep, up_evt, dn_evt, live_up, live_dn;
   logic [FTW_BITS:0]   sum, diff;

   btn_repeat_gen #(.HOLD_CYC(HOLD_CYC), .REP_CYC(REP_CYC)) u_rep_up (
      .clk   (clk),
      .rst_n (rst_n),
      .lvl   (up_lvl),
      .rep_p (up_rep)
   );

   btn_repeat_gen #(.HOLD_CYC(HOLD_CYC), .REP_CYC(REP_CYC)) u_rep_dn (
      .clk   (clk),
      .rst_n (rst_n),
      .lvl   (dn_lvl),
      .rep_p (dn_rep)
   );

   // Opposing events in the same cycle cancel, so at most one live
   // direction survives into the FSM.
   assign up_evt  = up_p | up_rep;
   assign dn_evt  = dn_p | dn_rep;
   assign live_up = up_evt & ~dn_evt;
   assign live_dn = dn_evt & ~up_evt;

   // One extra bit lets carry-out and borrow show up as the MSB.
   assign sum  = {1'b0, ftw_o} + {1'b0, step_q};
   assign diff = {1'b0, ftw_o} - {1'b0, step_q};

   // Next-state logic. In IDLE a pending event outranks a live one; a live
   // event that arrives while a pending one is served is itself pended.
   // In LOAD the offered word is frozen and new events only touch the
   // one-deep pending flags.
   always_comb begin
      state_d    = state_q;
      ftw_d      = ftw_o;
      valid_d    = ftw_valid;
      at_limit_d = 1'b0;
      pend_up_d  = pend_up;
      pend_dn_d  = pend_dn;
      go_up      = 1'b0;
      go_dn      = 1'b0;
      nxt        = ftw_o;
      clamp      = 1'b0;
      case (state_q)
         IDLE: begin
            if (pend_up || pend_dn) begin
               go_up     = pend_up;
               go_dn     = pend_dn;
               pend_up_d = live_up;
               pend_dn_d = live_dn;
            end else begin
               go_up = live_up;
               go_dn = live_dn;
            end
            if (go_up) begin
               if (sum > MAX_W) begin
                  nxt   = FTW_BITS'(FTW_MAX);
                  clamp = 1'b1;
               end else begin
                  nxt = sum[FTW_BITS-1:0];
               end
            end else if (go_dn) begin
               if (diff[FTW_BITS] || (diff < MIN_W)) begin
                  nxt   = FTW_BITS'(FTW_MIN);
                  clamp = 1'b1;
               end else begin
                  nxt = diff[FTW_BITS-1:0];
               end
            end
            at_limit_d = clamp;
            if ((go_up || go_dn) && (nxt != ftw_o)) begin
               ftw_d   = nxt;
               valid_d = 1'b1;
               state_d = LOAD;
            end
         end
         LOAD: begin
            if (ftw_ready) begin
               valid_d = 1'b0;
               state_d = IDLE;
            end
            if (live_up) begin
               if (pend_dn) begin
                  pend_up_d = 1'b0;
                  pend_dn_d = 1'b0;
               end else begin
                  pend_up_d = 1'b1;
               end
            end else if (live_dn) begin
               if (pend_up) begin
                  pend_up_d = 1'b0;
                  pend_dn_d = 1'b0;
               end else begin
                  pend_dn_d = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // FSM and offered-word registers. Reset re-offers FTW_RESET so the
   // accumulator is reconfigured, dropping any handshake in flight.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= LOAD;
         ftw_o     <= FTW_BITS'(FTW_RESET);
         ftw_valid <= 1'b1;
         at_limit  <= 1'b0;
         pend_up   <= 1'b0;
         pend_dn   <= 1'b0;
      end else begin
         state_q   <= state_d;
         ftw_o     <= ftw_d;
         ftw_valid <= valid_d;
         at_limit  <= at_limit_d;
         pend_up   <= pend_up_d;
         pend_dn   <= pend_dn_d;
      end
   end

   // Decade step selector, independent of the FSM. Multiply by ten is
   // built from two shifts; the last level wraps back to the base step.
   // Only future requests see the new step, never a word already offered.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         step_idx <= 3'd0;
         step_q   <= FTW_BITS'(STEP_BASE);
      end else if (step_p) begin
         if (step_idx == LAST_IDX) begin
            step_idx <= 3'd0;
            step_q   <= FTW_BITS'(STEP_BASE);
         end else begin
            step_idx <= step_idx + 3'd1;
            step_q   <= (step_q << 3) + (step_q << 1);
         end
      end
   end

endmodule
